// File: rtl/speech256_pkg.sv
// Shared types and constants for the Speech256 host-side allophone path.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package speech256_pkg;

    // Width of one allophone code as accepted by the speech core.
    localparam int ALLO_W = 6;

    typedef logic [ALLO_W-1:0] allo_t;

    // Load-handshake sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STROBE   = 2'd1,
        ACK      = 2'd2,
        WAIT_LDQ = 2'd3
    } seq_state_t;

    // Pause allophones, handy as filler codes in stimulus.
    localparam allo_t PA1 = 6'h00;
    localparam allo_t PA2 = 6'h01;
    localparam allo_t PA3 = 6'h02;
    localparam allo_t PA4 = 6'h03;
    localparam allo_t PA5 = 6'h04;

endpackage

// File: rtl/allophone_fifo.sv
// Circular-buffer FIFO of allophone codes with occupancy counter and flush.
// Latency: a push is visible at dout/level one cycle later; no write-to-read bypass.
// Backpressure: a push while full is dropped, even if a pop happens the same cycle.
//
// Ports:
//   clk, rst_an     clock, synchronous active-low reset
//   push, din       write request and code
//   pop             read request; dout is the head entry, valid while !empty
//   flush           empties the buffer; wins over a same-cycle push or pop
//   level           entries held (0..DEPTH)
//   full, empty     decoded from level
module allophone_fifo
    import speech256_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_an,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  allo_t                  din,
    output allo_t                  dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    allo_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];

    // Full is judged on the pre-pop count, so a simultaneous pop never
    // opens room for a write that arrives while full.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two
    // makes the natural overflow the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (!rst_an || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/allophone_sequencer.sv
// Queues host allophone writes and feeds them to the Speech256 core, one per ldq request.
// Latency: host_wr at edge N into an empty queue with ldq_in high -> data_stb after edge N+1.
// Backpressure: host sees host_full; writes while full are dropped and flagged in overflow.
//
// Ports:
//   clk, rst_an          clock, synchronous active-low reset
//   host_data, host_wr   allophone code and write strobe from the host
//   flush                drop queued codes, clear overflow/timeout
//   host_full, level     queue full flag and occupancy
//   ldq_in               core load request (high = core can take a code)
//   data_out, data_stb   code and one-cycle load strobe to the core
//   idle                 queue empty, sequencer idle and core requesting (utterance done)
//   overflow             sticky: write attempted while full
//   timeout              sticky: core never dropped ldq within ACK_TIMEOUT cycles
module allophone_sequencer
    import speech256_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_an,
    input  logic [ALLO_W-1:0]      host_data,
    input  logic                   host_wr,
    input  logic                   flush,
    output logic                   host_full,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   ldq_in,
    output logic [ALLO_W-1:0]      data_out,
    output logic                   data_stb,
    output logic                   idle,
    output logic                   overflow,
    output logic                   timeout
);

    localparam int            TW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(ACK_TIMEOUT);

    seq_state_t     state;
    logic [TW-1:0]  timer;
    allo_t          fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;

    // A new code is launched only from IDLE; flush suppresses the launch so
    // a code being discarded can never also be strobed.
    assign pop = (state == IDLE) && !fifo_empty && ldq_in && !flush;

    allophone_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_an (rst_an),
        .push   (host_wr),
        .pop    (pop),
        .flush  (flush),
        .din    (host_data),
        .dout   (fifo_head),
        .level  (level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign host_full = fifo_full;
    assign idle      = fifo_empty && (state == IDLE) && ldq_in;

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            state    <= IDLE;
            data_out <= '0;
            data_stb <= 1'b0;
            timer    <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_out <= fifo_head;
                        data_stb <= 1'b1;
                        state    <= STROBE;
                    end
                end
                STROBE: begin
                    data_stb <= 1'b0;
                    timer    <= '0;
                    state    <= ACK;
                end
                ACK: begin
                    // Core acknowledges a load by dropping ldq. If it never
                    // does, give up after ACK_TIMEOUT cycles so the queue
                    // keeps draining. The timer stops at T_MAX, never wraps.
                    if (!ldq_in) begin
                        state <= WAIT_LDQ;
                    end else if (timer == T_MAX) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_LDQ: begin
                    // Core is speaking; it re-raises ldq when ready for more.
                    if (ldq_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A write colliding with flush is silently discarded, not an overflow.
            if (host_wr && fifo_full && !flush) begin
                overflow <= 1'b1;
            end

            // Flush clears the sticky flags but leaves any in-flight
            // handshake to finish on its own.
            if (flush) begin
                overflow <= 1'b0;
                timeout  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_allophone_sequencer.sv
// Directed bench for allophone_sequencer: vector table for queue/flag behaviour
// plus hand-written sequences for handshake timing, timeout and reset.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_allophone_sequencer;
    import speech256_pkg::*;

    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 1023;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_an;
    logic [ALLO_W-1:0] host_data;
    logic              host_wr;
    logic              flush;
    logic              host_full;
    logic [LW-1:0]     level;
    logic              ldq_in;
    logic [ALLO_W-1:0] data_out;
    logic              data_stb;
    logic              idle;
    logic              overflow;
    logic              timeout;

    always #5 clk = ~clk;

    allophone_sequencer #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_an    (rst_an),
        .host_data (host_data),
        .host_wr   (host_wr),
        .flush     (flush),
        .host_full (host_full),
        .level     (level),
        .ldq_in    (ldq_in),
        .data_out  (data_out),
        .data_stb  (data_stb),
        .idle      (idle),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Core model: ldq drops for edges S+2..S+6 after a strobe seen at edge S.
    bit core_auto = 1'b0;
    int core_cnt  = 0;

    // Strobe recorder.
    int  stb_dat [$];
    int  stb_cyc [$];
    bit  stb_prev = 1'b0;
    int  stb_wide = 0;

    typedef struct {
        string             name;
        logic              wr;
        logic [ALLO_W-1:0] d;
        logic              fl;
        logic              ldq;
        int                lvl;
        logic              full;
        logic              ovf;
        logic              stb;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (core_auto) begin
            if (data_stb) core_cnt = 1;
            else if (core_cnt != 0) core_cnt++;
            ldq_in = !(core_cnt >= 2 && core_cnt < 7);
            if (core_cnt >= 7) core_cnt = 0;
        end
    endtask

    task automatic step_rec();
        step();
        if (data_stb) begin
            stb_dat.push_back(int'(data_out));
            stb_cyc.push_back(cyc);
            if (stb_prev) stb_wide++;
        end
        stb_prev = data_stb;
    endtask

    task automatic clear_rec();
        stb_dat.delete();
        stb_cyc.delete();
        stb_prev = 1'b0;
        stb_wide = 0;
    endtask

    initial begin
        int          n_edge;
        int          s_edge;
        logic [5:0]  codes1 [3];
        logic [5:0]  codes6 [8];

        rst_an    = 1'b0;
        host_data = '0;
        host_wr   = 1'b0;
        flush     = 1'b0;
        ldq_in    = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst_level",    level,     0);
        chk("rst_full",     host_full, 0);
        chk("rst_data_out", data_out,  0);
        chk("rst_stb",      data_stb,  0);
        chk("rst_overflow", overflow,  0);
        chk("rst_timeout",  timeout,   0);
        chk("rst_idle",     idle,      1);
        rst_an = 1'b1;
        step();

        // ---------------- three codes through the core model ----------------
        codes1[0] = 6'h1B;
        codes1[1] = 6'h07;
        codes1[2] = 6'h2A;
        clear_rec();
        core_auto = 1'b1;
        n_edge    = 0;
        for (int i = 0; i < 3; i++) begin
            host_wr   = 1'b1;
            host_data = codes1[i];
            step_rec();
            if (i == 0) n_edge = cyc;
        end
        host_wr = 1'b0;
        for (int i = 0; i < 30; i++) step_rec();
        core_auto = 1'b0;
        ldq_in    = 1'b1;
        chk("seq_strobe_count", stb_dat.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < stb_dat.size()) chk($sformatf("seq_code%0d", i), stb_dat[i], int'(codes1[i]));
        end
        if (stb_cyc.size() > 0) chk("seq_first_latency", stb_cyc[0] - n_edge, 1);
        if (stb_cyc.size() > 1) chk("seq_spacing", stb_cyc[1] - stb_cyc[0], 8);
        chk("seq_stb_width", stb_wide, 0);
        chk("seq_idle_end", idle, 1);
        chk("seq_data_hold", data_out, 6'h2A);

        // ---------------- table: fill/overflow/flush, write+flush ----------------
        for (int i = 1; i <= 8; i++)
            vecs.push_back('{$sformatf("fill%0d", i), 1'b1, 6'(8'h10 + i), 1'b0, 1'b0,
                             i, (i == 8), 1'b0, 1'b0});
        vecs.push_back('{"write_full",    1'b1, 6'h3F, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"ovf_sticky",    1'b0, 6'h00, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"flush_full",    1'b0, 6'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"post_flush_a",  1'b0, 6'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"post_flush_b",  1'b0, 6'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lvl3_w1",       1'b1, PA2,   1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lvl3_w2",       1'b1, PA3,   1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lvl3_w3",       1'b1, PA4,   1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"wr_and_flush",  1'b1, 6'h33, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"discard_a",     1'b0, 6'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"discard_b",     1'b0, 6'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            host_wr   = vecs[i].wr;
            host_data = vecs[i].d;
            flush     = vecs[i].fl;
            ldq_in    = vecs[i].ldq;
            step();
            chk({vecs[i].name, "_level"}, level,     vecs[i].lvl);
            chk({vecs[i].name, "_full"},  host_full, vecs[i].full);
            chk({vecs[i].name, "_ovf"},   overflow,  vecs[i].ovf);
            chk({vecs[i].name, "_stb"},   data_stb,  vecs[i].stb);
        end
        host_wr = 1'b0;
        flush   = 1'b0;
        ldq_in  = 1'b1;

        // ---------------- push and pop together at DEPTH-1 ----------------
        ldq_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            codes6[i] = 6'(8'h20 + i);
            host_wr   = 1'b1;
            host_data = codes6[i];
            step();
        end
        codes6[7] = 6'h31;
        chk("pp_level_pre", level, 7);
        clear_rec();
        core_auto = 1'b1;
        ldq_in    = 1'b1;
        host_data = codes6[7];
        step_rec();
        host_wr = 1'b0;
        chk("pp_level",  level,     7);
        chk("pp_full",   host_full, 0);
        chk("pp_ovf",    overflow,  0);
        chk("pp_stb",    data_stb,  1);
        for (int i = 0; i < 70; i++) step_rec();
        core_auto = 1'b0;
        ldq_in    = 1'b1;
        chk("pp_strobe_count", stb_dat.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < stb_dat.size()) chk($sformatf("pp_order%0d", i), stb_dat[i], int'(codes6[i]));
        end
        chk("pp_drained", level, 0);

        // ---------------- ack timeout ----------------
        host_wr   = 1'b1;
        host_data = 6'h15;
        step();
        host_data = 6'h2C;
        step();
        host_wr = 1'b0;
        s_edge  = cyc;
        chk("to_first_stb",  data_stb, 1);
        chk("to_first_code", data_out, 6'h15);
        for (int i = 0; i < ACK_TIMEOUT + 1; i++) step();
        chk("to_before", timeout, 0);
        chk("to_hold",   data_out, 6'h15);
        step();
        chk("to_cycle",  cyc - s_edge, ACK_TIMEOUT + 2);
        chk("to_set",    timeout, 1);
        chk("to_level",  level, 1);
        step();
        chk("to_next_stb",  data_stb, 1);
        chk("to_next_code", data_out, 6'h2C);

        // ---------------- reset during ACK with two queued ----------------
        host_wr   = 1'b1;
        host_data = PA5;
        step();
        host_data = 6'h0E;
        step();
        host_wr = 1'b0;
        chk("ra_level_pre",   level,   2);
        chk("ra_timeout_pre", timeout, 1);
        rst_an = 1'b0;
        step();
        chk("ra_level",    level,     0);
        chk("ra_full",     host_full, 0);
        chk("ra_data_out", data_out,  0);
        chk("ra_stb",      data_stb,  0);
        chk("ra_overflow", overflow,  0);
        chk("ra_timeout",  timeout,   0);
        rst_an = 1'b1;
        clear_rec();
        for (int i = 0; i < 12; i++) step_rec();
        chk("ra_no_strobe", stb_dat.size(), 0);
        chk("ra_idle", idle, 1);
        host_wr   = 1'b1;
        host_data = 6'h0A;
        step();
        host_wr = 1'b0;
        step();
        chk("ra_new_stb",  data_stb, 1);
        chk("ra_new_code", data_out, 6'h0A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
